imem_boot_loader: RTL and testbench

- Boot-time controller for the instruction memory. Receives a framed byte stream from the host link (UART receiver or debug bridge) and sequences single-cycle word writes into the instruction memory write port.
- Holds the pipeline CPU in reset/stall until a complete, checksum-verified program image is resident.
- Sits between the host byte link and the instruction memory write port. It also drives the CPU hold line.

---
 rtl/imem_boot_loader_pkg.sv | 25 ++
 rtl/imem_word_packer.sv | 47 ++++
 rtl/imem_boot_loader.sv | 134 +++++++++++++
 tb/tb_imem_boot_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
// The memory size comes from the global IMEM_ADDR_BITS macro so that the loader and the memory agree.
`ifndef IMEM_ADDR_BITS
`define IMEM_ADDR_BITS 10
`endif

package imem_boot_loader_pkg;

  localparam int IMEM_AW_DEF    = `IMEM_ADDR_BITS;
  localparam int IMEM_SIZE_B    = 1 << IMEM_AW_DEF;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_LEN        = 2;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Big-endian 8-to-32 shift register with a byte index, a running XOR checksum
// and a flag that marks a freshly completed word.
module imem_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              shift_en_i,
  input  logic [7:0]        byte_i,
  output logic [31:0]       word_o,
  output logic [7:0]        csum_o,
  output logic [BIDX_W-1:0] idx_o,
  output logic              word_full_o
);

  logic [31:0]       word_q;
  logic [7:0]        csum_q;
  logic [BIDX_W-1:0] idx_q;
  logic              full_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      csum_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else if (clear_i) begin
      word_q <= '0;
      csum_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else if (shift_en_i) begin
      // First byte of a word ends up in [31:24] after four shifts.
      word_q <= {word_q[23:0], byte_i};
      csum_q <= csum_q ^ byte_i;
      idx_q  <= idx_q + BIDX_W'(1);
      full_q <= (idx_q == BIDX_W'(BYTES_PER_WORD - 1));
    end
  end

  assign word_o      = word_q;
  assign csum_o      = csum_q;
  assign idx_o       = idx_q;
  assign word_full_o = full_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte frame from the host
// link, writes it word by word into instruction memory and holds the CPU until done.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int IMEM_ADDR_WIDTH = IMEM_AW_DEF,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_req,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 imem_we,
  output logic [31:0]          imem_waddr,
  output logic [31:0]          imem_wdata,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic                 load_err,
  output logic [LEN_WIDTH-1:0] words_loaded
);

  localparam int unsigned MAX_WORDS = 32'd1 << (IMEM_ADDR_WIDTH - 2);

  state_e               state_q, state_d;
  logic [7:0]           len_hi_q, len_hi_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic [LEN_WIDTH-1:0] words_q, words_d;

  logic                 pk_clear, pk_shift;
  logic [31:0]          pk_word;
  logic [7:0]           pk_csum;
  logic [BIDX_W-1:0]    pk_idx;
  logic                 pk_full;
  logic                 accept;
  logic [LEN_WIDTH-1:0] hdr_count;
  logic [IMEM_ADDR_WIDTH-1:0] waddr_trunc;

  imem_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (pk_clear),
    .shift_en_i  (pk_shift),
    .byte_i      (in_data),
    .word_o      (pk_word),
    .csum_o      (pk_csum),
    .idx_o       (pk_idx),
    .word_full_o (pk_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_LEN_HI;
      len_hi_q <= '0;
      count_q  <= '0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      count_q  <= count_d;
      words_q  <= words_d;
    end
  end

  assign hdr_count   = LEN_WIDTH'({len_hi_q, in_data});
  assign waddr_trunc = IMEM_ADDR_WIDTH'({words_q, 2'b00});

  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    count_d      = count_q;
    words_d      = words_q;
    pk_clear     = 1'b0;
    pk_shift     = 1'b0;
    in_ready     = 1'b0;
    imem_we      = 1'b0;
    imem_waddr   = '0;
    imem_wdata   = '0;
    cpu_hold     = 1'b1;
    load_done    = 1'b0;
    load_err     = 1'b0;
    words_loaded = words_q;

    // Outputs decode from registered state only, so in_ready never depends on in_valid.
    case (state_q)
      ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK: in_ready = 1'b1;
      ST_WRITE: begin
        imem_we    = pk_full;
        imem_waddr = 32'(waddr_trunc);
        imem_wdata = pk_word;
      end
      ST_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
      end
      ST_ERR:  load_err = 1'b1;
      default: ;
    endcase

    accept = in_valid && in_ready;

    case (state_q)
      ST_LEN_HI: if (accept) begin
        len_hi_d = in_data;
        state_d  = ST_LEN_LO;
      end
      ST_LEN_LO: if (accept) begin
        count_d = hdr_count;
        if (32'(hdr_count) > MAX_WORDS)   state_d = ST_ERR;
        else if (hdr_count == '0)         state_d = ST_CHECK;
        else                              state_d = ST_DATA;
      end
      ST_DATA: if (accept) begin
        pk_shift = 1'b1;
        if (pk_idx == BIDX_W'(BYTES_PER_WORD - 1)) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        words_d = words_q + LEN_WIDTH'(1);
        state_d = (words_d == count_q) ? ST_CHECK : ST_DATA;
      end
      ST_CHECK: if (accept) begin
        state_d = (in_data == pk_csum) ? ST_DONE : ST_ERR;
      end
      ST_DONE, ST_ERR: if (load_req) begin
        state_d  = ST_LEN_HI;
        words_d  = '0;
        pk_clear = 1'b1;
      end
      default: state_d = ST_LEN_HI;
    endcase
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed frames from the test plan plus random frames,
// compared against a frame-level reference model.
module tb_imem_boot_loader;

  localparam int AW    = 10;
  localparam int LW    = 16;
  localparam int MAXW  = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          load_req;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [31:0]   imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [LW-1:0] words_loaded;

  imem_boot_loader #(.IMEM_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_req     (load_req),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int mis_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] wq[$];
  int          wcyc[$];
  int          we_rdy = 0;
  int          acc[$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wq.push_back({imem_waddr, imem_wdata});
      wcyc.push_back(cyc);
      if (in_ready !== 1'b0) we_rdy++;
    end
  end

  logic [7:0]  stim[$];
  logic [63:0] exp_w[$];
  logic        exp_done, exp_err;
  int          exp_words;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp)
    else begin
      mis_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: parse header, assemble big-endian words, compare XOR checksum.
  task automatic model();
    int cnt;
    logic [7:0]  x;
    logic [31:0] w;
    cnt = {stim[0], stim[1]};
    exp_w.delete();
    x = 8'h00;
    if (cnt > MAXW) begin
      exp_err = 1'b1; exp_done = 1'b0; exp_words = 0;
    end else begin
      for (int k = 0; k < cnt; k++) begin
        w = {stim[2+4*k], stim[3+4*k], stim[4+4*k], stim[5+4*k]};
        x = x ^ stim[2+4*k] ^ stim[3+4*k] ^ stim[4+4*k] ^ stim[5+4*k];
        exp_w.push_back({32'(k * 4), w});
      end
      exp_words = cnt;
      exp_done  = (stim[2+4*cnt] == x);
      exp_err   = !exp_done;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("byte_accepted", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    acc.push_back(cyc);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_we"},       32'(imem_we),  32'd0);
    check({tag, "_waddr"},    imem_waddr,    32'd0);
    check({tag, "_wdata"},    imem_wdata,    32'd0);
    check({tag, "_hold"},     32'(cpu_hold), 32'd1);
    check({tag, "_done"},     32'(load_done), 32'd0);
    check({tag, "_err"},      32'(load_err), 32'd0);
    check({tag, "_words"},    32'(words_loaded), 32'd0);
  endtask

  task automatic restart();
    if (load_done === 1'b1 || load_err === 1'b1) begin
      @(negedge clk);
      load_req = 1'b1;
      @(posedge clk);
      #1;
      load_req = 1'b0;
      check("reload_hold",  32'(cpu_hold), 32'd1);
      check("reload_done",  32'(load_done), 32'd0);
      check("reload_err",   32'(load_err), 32'd0);
      check("reload_words", 32'(words_loaded), 32'd0);
      check("reload_ready", 32'(in_ready), 32'd1);
    end
  endtask

  task automatic run_frame(input string tag, input int max_gap);
    restart();
    wq.delete(); wcyc.delete(); acc.delete(); we_rdy = 0;
    model();
    foreach (stim[i]) send_byte(stim[i], $urandom_range(0, max_gap));
    check({tag, "_done"},  32'(load_done), 32'(exp_done));
    check({tag, "_err"},   32'(load_err), 32'(exp_err));
    check({tag, "_hold"},  32'(cpu_hold), 32'(!exp_done));
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
    repeat (3) @(negedge clk);
    check({tag, "_nwrites"}, 32'(wq.size()), 32'(exp_w.size()));
    check({tag, "_we_ready"}, 32'(we_rdy), 32'd0);
    for (int k = 0; k < exp_w.size(); k++) begin
      if (k < wq.size()) begin
        check({tag, "_waddr"}, wq[k][63:32], exp_w[k][63:32]);
        check({tag, "_wdata"}, wq[k][31:0],  exp_w[k][31:0]);
        check({tag, "_wlat"},  32'(wcyc[k]), 32'(acc[4*k+5]));
      end
    end
  endtask

  task automatic random_frame(input bit oversize);
    int cnt;
    logic [7:0] x, b;
    stim.delete();
    cnt = oversize ? $urandom_range(MAXW + 1, 65535) : $urandom_range(0, 5);
    stim.push_back(8'(cnt >> 8));
    stim.push_back(8'(cnt));
    if (!oversize) begin
      x = 8'h00;
      for (int i = 0; i < cnt * 4; i++) begin
        b = 8'($urandom);
        x ^= b;
        stim.push_back(b);
      end
      if ($urandom_range(0, 3) == 0) stim.push_back(x ^ 8'($urandom_range(1, 255)));
      else                           stim.push_back(x);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("rst_low");
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_rel");

    stim = {8'h00, 8'h02, 8'h3C, 8'h01, 8'h10, 8'h01, 8'h34, 8'h3D, 8'h00, 8'h3C, 8'h19};
    run_frame("nominal", 0);

    stim = {8'h00, 8'h02, 8'h3C, 8'h01, 8'h10, 8'h01, 8'h34, 8'h3D, 8'h00, 8'h3C, 8'h18};
    run_frame("badsum", 0);

    stim = {8'h01, 8'h01};
    run_frame("oversize", 0);

    stim = {8'h00, 8'h00, 8'h00};
    run_frame("empty", 0);

    stim = {8'h00, 8'h02, 8'h3C, 8'h01, 8'h10, 8'h01, 8'h34, 8'h3D, 8'h00, 8'h3C, 8'h19};
    run_frame("backpr", 5);
    stim = {8'h00, 8'h01, 8'hAD, 8'h09, 8'h00, 8'h00, 8'hA4};
    run_frame("oneword", 2);

    // Reset asserted after the second data byte of a nominal frame.
    restart();
    stim = {8'h00, 8'h02, 8'h3C, 8'h01, 8'h10, 8'h01, 8'h34, 8'h3D, 8'h00, 8'h3C, 8'h19};
    for (int i = 0; i < 4; i++) send_byte(stim[i], 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_vals("midrst_async");
    repeat (2) @(negedge clk);
    check_reset_vals("midrst_held");
    rst = 1'b1;
    run_frame("after_rst", 1);

    for (int n = 0; n < 12; n++) begin
      random_frame(n == 5);
      run_frame("random", 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
